// File: rtl/f1_start_sequencer_if.sv
// F1 start-light sequencer interface: stimulus inputs and sequence/readout outputs.
// Carries no logic and adds no latency.
// No backpressure: every signal is a level or a single-cycle strobe.
interface f1_start_sequencer_if #(
  parameter int DATA_WIDTH  = 7,
  parameter int NUM_LIGHTS  = 8,
  parameter int REACT_WIDTH = 16
);
  logic                   trigger;
  logic                   tick;
  logic                   btn;
  logic [DATA_WIDTH-1:0]  rnd;
  logic                   rnd_en;
  logic [NUM_LIGHTS-1:0]  lights;
  logic                   go;
  logic [REACT_WIDTH-1:0] react_time;
  logic                   react_valid;
  logic                   jump_start;
  logic                   busy;

  // Stimulus side: drives the requests and receives the sequence outputs.
  modport master (
    output trigger, tick, btn, rnd,
    input  rnd_en, lights, go, react_time, react_valid, jump_start, busy
  );

  // Sequencer side.
  modport slave (
    input  trigger, tick, btn, rnd,
    output rnd_en, lights, go, react_time, react_valid, jump_start, busy
  );
endinterface

// File: rtl/f1_start_sequencer.sv
// F1-style start lights: one light per STEP_TICKS, a random hold, a go pulse, then reaction timing.
// All outputs are registered one clk after the sampled condition; busy and rnd_en decode the state.
// No backpressure: trigger rises during a sequence and btn presses while idle are dropped.
module f1_start_sequencer #(
  parameter int DATA_WIDTH  = 7,
  parameter int NUM_LIGHTS  = 8,
  parameter int STEP_TICKS  = 1000,
  parameter int REACT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  f1_start_sequencer_if.slave bus
);

  localparam int TICK_W = $clog2(STEP_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LIGHTS, DELAY, REACT, DONE} state_t;

  state_t                 state, state_n;
  logic                   trigger_q;
  logic                   trig_rise;
  logic [NUM_LIGHTS-1:0]  lights_q, lights_n;
  logic                   go_q, go_n;
  logic [REACT_WIDTH-1:0] react_time_q, react_time_n;
  logic                   react_valid_q, react_valid_n;
  logic                   jump_q, jump_n;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_n;
  logic [DATA_WIDTH-1:0]  delay_cnt_q, delay_cnt_n;
  logic [REACT_WIDTH-1:0] react_cnt_q, react_cnt_n;

  // A held-high trigger counts only once, on its rising edge.
  assign trig_rise = bus.trigger & ~trigger_q;

  // State register; reset aborts any sequence straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath decode; btn outranks tick wherever both are legal.
  always_comb begin
    state_n       = state;
    lights_n      = lights_q;
    go_n          = 1'b0;
    react_time_n  = react_time_q;
    react_valid_n = react_valid_q;
    jump_n        = jump_q;
    tick_cnt_n    = tick_cnt_q;
    delay_cnt_n   = delay_cnt_q;
    react_cnt_n   = react_cnt_q;
    case (state)
      IDLE, DONE: begin
        if (trig_rise) begin
          state_n       = LIGHTS;
          lights_n      = NUM_LIGHTS'(1);
          tick_cnt_n    = '0;
          react_time_n  = '0;
          react_valid_n = 1'b0;
          jump_n        = 1'b0;
        end
      end
      LIGHTS: begin
        if (bus.btn) begin
          state_n  = DONE;
          jump_n   = 1'b1;
          lights_n = '0;
        end else if (bus.tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_n = '0;
            if (&lights_q) begin
              state_n     = DELAY;
              // A zero draw would never expire, so it is treated as one tick.
              delay_cnt_n = (bus.rnd == '0) ? DATA_WIDTH'(1) : bus.rnd;
            end else begin
              lights_n = {lights_q[NUM_LIGHTS-2:0], 1'b1};
            end
          end else begin
            tick_cnt_n = tick_cnt_q + 1'b1;
          end
        end
      end
      DELAY: begin
        if (bus.btn) begin
          state_n  = DONE;
          jump_n   = 1'b1;
          lights_n = '0;
        end else if (bus.tick) begin
          if (delay_cnt_q == DATA_WIDTH'(1)) begin
            state_n     = REACT;
            lights_n    = '0;
            go_n        = 1'b1;
            react_cnt_n = '0;
          end else begin
            delay_cnt_n = delay_cnt_q - 1'b1;
          end
        end
      end
      REACT: begin
        if (bus.btn) begin
          state_n       = DONE;
          react_time_n  = react_cnt_q;
          react_valid_n = 1'b1;
        end else if (bus.tick && !(&react_cnt_q)) begin
          react_cnt_n = react_cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers; reset clears every output without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigger_q     <= 1'b0;
      lights_q      <= '0;
      go_q          <= 1'b0;
      react_time_q  <= '0;
      react_valid_q <= 1'b0;
      jump_q        <= 1'b0;
      tick_cnt_q    <= '0;
      delay_cnt_q   <= '0;
      react_cnt_q   <= '0;
    end else begin
      trigger_q     <= bus.trigger;
      lights_q      <= lights_n;
      go_q          <= go_n;
      react_time_q  <= react_time_n;
      react_valid_q <= react_valid_n;
      jump_q        <= jump_n;
      tick_cnt_q    <= tick_cnt_n;
      delay_cnt_q   <= delay_cnt_n;
      react_cnt_q   <= react_cnt_n;
    end
  end

  assign bus.lights      = lights_q;
  assign bus.go          = go_q;
  assign bus.react_time  = react_time_q;
  assign bus.react_valid = react_valid_q;
  assign bus.jump_start  = jump_q;
  assign bus.busy        = (state == LIGHTS) || (state == DELAY) || (state == REACT);
  // The LFSR keeps stirring between sequences and is frozen while one runs.
  assign bus.rnd_en      = (state == IDLE) || (state == DONE);

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer: table of full sequences plus hand-written corner cases.
// Outputs are sampled 1 time unit after each rising clk edge.
// No backpressure to model: stimulus is driven by level.
module tb_f1_start_sequencer;

  localparam int DW   = 7;
  localparam int NL   = 8;
  localparam int STEP = 2;
  localparam int RW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   go_count = 0;

  f1_start_sequencer_if #(.DATA_WIDTH(DW), .NUM_LIGHTS(NL), .REACT_WIDTH(RW)) bus ();

  f1_start_sequencer #(
    .DATA_WIDTH(DW), .NUM_LIGHTS(NL), .STEP_TICKS(STEP), .REACT_WIDTH(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Every negedge that sees go counts once, so a one-cycle pulse adds exactly one.
  always @(negedge clk) if (bus.go) go_count++;

  typedef struct {
    logic [DW-1:0] rnd;
    int            n_ticks;   // REACT ticks before the button
    bit            tie;       // tick asserted together with the button
    int            go_edges;  // clk edges from lights==FF to go
    logic [RW-1:0] react;     // expected react_time
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
  endtask

  task automatic wait_lights(input logic [NL-1:0] val, input string name);
    int cyc = 0;
    while (bus.lights !== val && cyc < 100) begin
      step();
      cyc++;
    end
    if (bus.lights !== val) check(name, 32'(bus.lights), 32'(val));
  endtask

  task automatic run_seq(input int idx, input vec_t v);
    int            g0;
    int            cyc;
    logic [NL-1:0] exp_l;
    logic [NL-1:0] prev;
    g0 = go_count;
    bus.rnd  = v.rnd;
    bus.tick = 1'b1;
    bus.btn  = 1'b0;
    pulse_trigger();
    check($sformatf("v%0d lights_first", idx), 32'(bus.lights), 32'h01);
    check($sformatf("v%0d busy_start", idx), 32'(bus.busy), 32'd1);
    check($sformatf("v%0d rnd_en_busy", idx), 32'(bus.rnd_en), 32'd0);
    check($sformatf("v%0d valid_cleared", idx), 32'(bus.react_valid), 32'd0);
    check($sformatf("v%0d time_cleared", idx), 32'(bus.react_time), 32'd0);
    exp_l = 8'h01;
    for (int k = 1; k < NL; k++) begin
      exp_l = {exp_l[NL-2:0], 1'b1};
      prev  = bus.lights;
      cyc   = 0;
      do begin step(); cyc++; end while (bus.lights == prev && cyc < 20);
      check($sformatf("v%0d light%0d_val", idx, k), 32'(bus.lights), 32'(exp_l));
      check($sformatf("v%0d light%0d_gap", idx, k), 32'(cyc), 32'(STEP));
    end
    cyc = 0;
    do begin step(); cyc++; end while (!bus.go && cyc < 300);
    check($sformatf("v%0d go_seen", idx), 32'(bus.go), 32'd1);
    check($sformatf("v%0d go_delay", idx), 32'(cyc), 32'(v.go_edges));
    check($sformatf("v%0d lights_out", idx), 32'(bus.lights), 32'h00);
    for (int i = 0; i < v.n_ticks; i++) step();
    bus.btn  = 1'b1;
    bus.tick = v.tie;
    step();
    bus.btn  = 1'b0;
    bus.tick = 1'b1;
    check($sformatf("v%0d react_time", idx), 32'(bus.react_time), 32'(v.react));
    check($sformatf("v%0d react_valid", idx), 32'(bus.react_valid), 32'd1);
    check($sformatf("v%0d jump_start", idx), 32'(bus.jump_start), 32'd0);
    check($sformatf("v%0d busy_done", idx), 32'(bus.busy), 32'd0);
    check($sformatf("v%0d rnd_en_done", idx), 32'(bus.rnd_en), 32'd1);
    check($sformatf("v%0d go_pulses", idx), 32'(go_count - g0), 32'd1);
  endtask

  initial begin
    int g0;
    vecs[0] = '{rnd: 7'd5,  n_ticks: 10, tie: 1'b0, go_edges: STEP + 5, react: 4'd10};
    vecs[1] = '{rnd: 7'd0,  n_ticks: 2,  tie: 1'b0, go_edges: STEP + 1, react: 4'd2};
    vecs[2] = '{rnd: 7'd1,  n_ticks: 0,  tie: 1'b0, go_edges: STEP + 1, react: 4'd0};
    vecs[3] = '{rnd: 7'd3,  n_ticks: 20, tie: 1'b0, go_edges: STEP + 3, react: 4'd15};
    vecs[4] = '{rnd: 7'd9,  n_ticks: 3,  tie: 1'b1, go_edges: STEP + 9, react: 4'd3};
    vecs[5] = '{rnd: 7'd12, n_ticks: 14, tie: 1'b1, go_edges: STEP + 12, react: 4'd14};

    bus.trigger = 1'b0;
    bus.tick    = 1'b0;
    bus.btn     = 1'b0;
    bus.rnd     = '0;

    // Reset state.
    repeat (3) step();
    check("rst lights", 32'(bus.lights), 32'h0);
    check("rst go", 32'(bus.go), 32'h0);
    check("rst react_time", 32'(bus.react_time), 32'h0);
    check("rst react_valid", 32'(bus.react_valid), 32'h0);
    check("rst jump_start", 32'(bus.jump_start), 32'h0);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst rnd_en", 32'(bus.rnd_en), 32'h1);
    rst = 1'b0;
    repeat (2) step();
    check("idle busy", 32'(bus.busy), 32'h0);

    // Full sequences from the table.
    for (int i = 0; i < 6; i++) run_seq(i, vecs[i]);

    // Button while DONE is ignored.
    bus.btn = 1'b1;
    repeat (3) step();
    bus.btn = 1'b0;
    check("done btn react_time", 32'(bus.react_time), 32'd14);
    check("done btn busy", 32'(bus.busy), 32'd0);

    // Jump start during LIGHTS.
    g0 = go_count;
    bus.rnd  = 7'd4;
    bus.tick = 1'b1;
    pulse_trigger();
    wait_lights(8'h07, "jump wait_07");
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    check("jump lights", 32'(bus.lights), 32'h0);
    check("jump flag", 32'(bus.jump_start), 32'h1);
    check("jump valid", 32'(bus.react_valid), 32'h0);
    check("jump busy", 32'(bus.busy), 32'h0);
    repeat (30) step();
    check("jump no_go", 32'(go_count - g0), 32'd0);
    check("jump lights_hold", 32'(bus.lights), 32'h0);
    pulse_trigger();
    check("restart jump_clear", 32'(bus.jump_start), 32'h0);
    check("restart lights", 32'(bus.lights), 32'h01);

    // Jump start during DELAY.
    bus.rnd = 7'd40;
    wait_lights(8'hFF, "jdelay wait_ff");
    repeat (STEP + 3) step();
    check("jdelay still_on", 32'(bus.lights), 32'hFF);
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    check("jdelay flag", 32'(bus.jump_start), 32'h1);
    check("jdelay lights", 32'(bus.lights), 32'h0);
    repeat (50) step();
    check("jdelay no_go", 32'(go_count - g0), 32'd0);

    // Trigger held high: exactly one sequence.
    g0 = go_count;
    bus.rnd = 7'd2;
    bus.trigger = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.btn = (i == 25);
      step();
    end
    bus.btn = 1'b0;
    bus.trigger = 1'b0;
    check("held go_once", 32'(go_count - g0), 32'd1);
    check("held react_time", 32'(bus.react_time), 32'd6);
    check("held valid", 32'(bus.react_valid), 32'd1);
    check("held busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-DELAY.
    g0 = go_count;
    bus.rnd = 7'd50;
    step();
    pulse_trigger();
    wait_lights(8'hFF, "areset wait_ff");
    repeat (STEP + 2) step();
    check("areset pre_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #2;
    check("areset lights", 32'(bus.lights), 32'h0);
    check("areset busy", 32'(bus.busy), 32'h0);
    check("areset go", 32'(bus.go), 32'h0);
    check("areset rnd_en", 32'(bus.rnd_en), 32'h1);
    check("areset valid", 32'(bus.react_valid), 32'h0);
    #1;
    rst = 1'b0;
    repeat (80) step();
    check("areset no_go", 32'(go_count - g0), 32'd0);
    check("areset idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
